// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by the fetch unit.
package cpu_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR             = 32'h0000_0013;
    localparam int          FETCH_TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-side memory bus between the fetch unit and the bus arbiter.
interface instr_fetch_if;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_ren, mem_addr, input  mem_ack, mem_rdata);
    modport slave  (input  mem_ren, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_timer.sv
// Fetch timeout counter: cleared while the fetch FSM is idle, counts unacked REQ cycles.
module fetch_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nRST)    cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    // Flags the cycle whose increment brings the count to TIMEOUT, so the
    // abort lands exactly TIMEOUT request cycles after the fetch started.
    assign expired = en && (({1'b0, cnt} + 1'b1) == (CNT_W+1)'(TIMEOUT));
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: consumes PCaddr, reads instruction memory, strobes iready.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int          TIMEOUT  = FETCH_TIMEOUT_DEFAULT,
    parameter int          CNT_W    = 8,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic         clk,
    input  logic         nRST,
    input  logic [31:0]  PCaddr,
    input  logic         halt,
    input  logic         dmem_pending,
    instr_fetch_if.master mem,
    output logic [31:0]  instr,
    output logic         iready,
    output logic         ifault
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_REQ  = 2'(REQ);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0] state;
    logic       start, tmr_clr, tmr_en, expired;

    // Data-side traffic owns the bus until it drops; only checked before a fetch starts.
    assign start   = !halt && !dmem_pending && !ifault;
    assign tmr_clr = (state == S_IDLE);
    assign tmr_en  = (state == S_REQ) && !mem.mem_ack;

    fetch_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .nRST    (nRST),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state        <= S_IDLE;
            mem.mem_ren  <= 1'b0;
            mem.mem_addr <= '0;
            instr        <= NOP_WORD;
            iready       <= 1'b0;
            ifault       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (PCaddr[1:0] != 2'b00) begin
                            ifault <= 1'b1;
                        end else begin
                            mem.mem_addr <= PCaddr;
                            mem.mem_ren  <= 1'b1;
                            state        <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        instr       <= mem.mem_rdata;
                        iready      <= 1'b1;
                        mem.mem_ren <= 1'b0;
                        state       <= S_DONE;
                    end else if (expired) begin
                        mem.mem_ren <= 1'b0;
                        ifault      <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_DONE: begin
                    iready <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, random fetches, hand-written corner cases.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] PCaddr;
    logic        halt, dmem_pending;
    logic [31:0] instr;
    logic        iready, ifault;

    instr_fetch_if bus();

    instr_fetch #(.TIMEOUT(8), .CNT_W(4), .NOP_WORD(32'h0000_0013)) dut (
        .clk          (clk),
        .nRST         (nRST),
        .PCaddr       (PCaddr),
        .halt         (halt),
        .dmem_pending (dmem_pending),
        .mem          (bus.master),
        .instr        (instr),
        .iready       (iready),
        .ifault       (ifault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference instruction memory contents
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder: ack after 'lat' wait cycles; 'junk' toggles ack while no request
    int lat = 0;
    int wcnt = 0;
    bit noack = 0;
    bit junk = 0;
    always @(negedge clk) begin
        if (bus.mem_ren && !noack) begin
            if (wcnt >= lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = memf(bus.mem_addr);
                wcnt = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hBAD0_BAD0;
                wcnt++;
            end
        end else begin
            bus.mem_ack   = junk ? ~bus.mem_ack : 1'b0;
            bus.mem_rdata = 32'hBAD0_BAD0;
            wcnt = 0;
        end
    end

    // iready must never be high on two consecutive cycles
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (nRST && iready) chk("iready_pulse", {31'd0, prev_rdy}, 32'd0);
        prev_rdy = iready;
    end

    typedef struct {
        logic [31:0] pc;
        int          lat;
        int          dmem;     // cycles of dmem_pending before the fetch may start
        bit          dreq;     // raise dmem_pending while the fetch is in REQ
        logic [31:0] pcmid;    // nonzero: change PCaddr mid-REQ
        bit          hlt;      // raise halt mid-REQ
        logic [31:0] exp_instr;
        int          exp_lat;  // cycles from presenting PCaddr to seeing iready
        int          exp_ren;  // cycles mem_ren is high
    } vec_t;

    function automatic vec_t mkvec(input logic [31:0] pc, input int l, input int d,
                                   input bit dr, input logic [31:0] pm, input bit h);
        vec_t v;
        v.pc = pc; v.lat = l; v.dmem = d; v.dreq = dr; v.pcmid = pm; v.hlt = h;
        v.exp_instr = memf(pc);
        v.exp_lat   = d + 2 + l;
        v.exp_ren   = l + 1;
        return v;
    endfunction

    // Presents one fetch; returns cycles until iready and cycles mem_ren was seen.
    task automatic do_fetch(input vec_t v, output int lt, output int rc);
        bit seen = 0;
        PCaddr = v.pc;
        lat = v.lat;
        dmem_pending = (v.dmem > 0);
        lt = 0; rc = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            lt++;
            if (lt == v.dmem) dmem_pending = 1'b0;
            if (bus.mem_ren) begin
                rc++;
                chk("mem_addr_held", bus.mem_addr, v.pc);
                if (v.pcmid != 0) PCaddr = v.pcmid;
                if (v.dreq) dmem_pending = 1'b1;
                if (v.hlt) halt = 1'b1;
            end
            if (iready) seen = 1;
        end
        dmem_pending = 1'b0;
        chk("iready_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lt, rc;
        do_fetch(v, lt, rc);
        chk({tag, "_latency"}, lt, v.exp_lat);
        chk({tag, "_ren_cycles"}, rc, v.exp_ren);
        chk({tag, "_instr"}, instr, v.exp_instr);
        @(negedge clk);
        chk({tag, "_iready_drop"}, {31'd0, iready}, 32'd0);
        if (v.hlt) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk({tag, "_halt_no_ren"}, {31'd0, bus.mem_ren}, 32'd0);
            end
            halt = 1'b0;
        end
    endtask

    vec_t tbl[8];

    initial begin
        int rc, nr;
        logic [31:0] last;
        nRST = 1'b0; PCaddr = 32'h0; halt = 1'b0; dmem_pending = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

        tbl[0] = mkvec(32'h0000_0100, 0, 0, 0, 32'h0,         0);
        tbl[1] = mkvec(32'h0000_0104, 0, 0, 0, 32'h0,         0);
        tbl[2] = mkvec(32'h0000_0100, 4, 0, 0, 32'h0000_0200, 0);
        tbl[3] = mkvec(32'h0000_0200, 0, 0, 0, 32'h0,         0);
        tbl[4] = mkvec(32'h0000_0204, 0, 3, 0, 32'h0,         0);
        tbl[5] = mkvec(32'h0000_0208, 2, 0, 1, 32'h0,         0);
        tbl[6] = mkvec(32'h0000_020C, 1, 0, 0, 32'h0,         1);
        tbl[7] = mkvec(32'h0000_0210, 0, 0, 0, 32'h0,         0);

        // Reset with ack toggling
        junk = 1;
        repeat (2) @(negedge clk);
        chk("rst_ren",    {31'd0, bus.mem_ren}, 32'd0);
        chk("rst_iready", {31'd0, iready},      32'd0);
        chk("rst_instr",  instr,                32'h0000_0013);
        chk("rst_ifault", {31'd0, ifault},      32'd0);
        chk("rst_addr",   bus.mem_addr,         32'd0);
        junk = 0;
        halt = 1'b1;
        nRST = 1'b1;
        @(negedge clk);
        chk("halt_idle_ren", {31'd0, bus.mem_ren}, 32'd0);
        halt = 1'b0;

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v = mkvec({16'h0001, 14'($urandom), 2'b00}, int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 32'h0, 0);
            run_vec($sformatf("rnd%0d", i), v);
        end

        // Timeout: no ack for 8 request cycles aborts with a sticky fault
        last = instr;
        noack = 1;
        PCaddr = 32'h0000_0300;
        rc = 0; nr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_ren) rc++;
            if (iready) nr++;
        end
        noack = 0;
        chk("to_ren_cycles", rc, 32'd8);
        chk("to_ifault",     {31'd0, ifault}, 32'd1);
        chk("to_instr",      instr, last);
        chk("to_no_iready",  nr, 32'd0);
        PCaddr = 32'h0000_0304;
        rc = 0;
        repeat (5) begin @(negedge clk); if (bus.mem_ren) rc++; end
        chk("to_sticky_no_fetch", rc, 32'd0);

        // Reset mid-REQ: request drops, no iready
        nRST = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        PCaddr = 32'h0000_0400; lat = 5;
        repeat (3) @(negedge clk);
        chk("rreq_ren_up", {31'd0, bus.mem_ren}, 32'd1);
        nRST = 1'b0;
        PCaddr = 32'h0000_0102;
        @(negedge clk);
        chk("rreq_ren_drop", {31'd0, bus.mem_ren}, 32'd0);
        chk("rreq_iready",   {31'd0, iready},      32'd0);
        @(negedge clk);
        lat = 0;
        nRST = 1'b1;

        // Misaligned PC faults immediately and never requests
        @(negedge clk);
        chk("mis_ifault", {31'd0, ifault}, 32'd1);
        PCaddr = 32'h0000_0104;
        rc = 0; nr = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_ren) rc++;
            if (iready) nr++;
        end
        chk("mis_no_ren",    rc, 32'd0);
        chk("mis_no_iready", nr, 32'd0);
        chk("mis_sticky",    {31'd0, ifault}, 32'd1);
        nRST = 1'b0;
        @(negedge clk);
        chk("mis_cleared", {31'd0, ifault}, 32'd0);
        nRST = 1'b1;
        run_vec("post", mkvec(32'h0000_0108, 1, 0, 0, 32'h0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
